// File: rtl/vid_line_prefetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vid_linebuf_pkg
//  Brief    : Shared types and default geometry for the video line prefetcher.
//  Revision : 1.0 - initial release
// ============================================================================
package vid_linebuf_pkg;

  localparam int unsigned c_H_RES_DEFAULT = 640;
  localparam int unsigned c_V_RES_DEFAULT = 480;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/vid_line_prefetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : vid_line_prefetch_if
//  Brief    : Burst read port between the line prefetcher (master) and the
//             pixel-side port of the memory controller (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface vid_line_prefetch_if #(
  parameter int unsigned ADDR_W = 30
) ();
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_data_valid;
  logic [31:0]       rd_data;

  modport master (
    output rd_req, rd_addr,
    input  rd_ack, rd_data_valid, rd_data
  );

  modport slave (
    input  rd_req, rd_addr,
    output rd_ack, rd_data_valid, rd_data
  );
endinterface
`default_nettype wire

// File: rtl/vid_line_prefetch_linebuf_dpram.sv
`default_nettype none
// ============================================================================
//  Module   : linebuf_dpram
//  Brief    : Simple dual-port line RAM, two banks of H_RES pixels. One write
//             port, one registered read port that outputs 0 when not enabled.
//  Revision : 1.0 - initial release
// ============================================================================
module linebuf_dpram
  import vid_linebuf_pkg::*;
#(
  parameter int unsigned H_RES = c_H_RES_DEFAULT,
  parameter int unsigned IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic             wr_bank_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  pixel_t           wr_data_i,
  input  logic             rd_en_i,
  input  logic             rd_bank_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output pixel_t           rd_data_o
);

  localparam int unsigned RAM_AW = $clog2(2 * H_RES);

  pixel_t              mem_q [0:2*H_RES-1];
  pixel_t              rd_data_q;
  logic   [RAM_AW-1:0] w_wr_addr;
  logic   [RAM_AW-1:0] w_rd_addr;

  // Bank 1 occupies the upper H_RES words of the array.
  assign w_wr_addr = RAM_AW'(wr_idx_i) + (wr_bank_i ? RAM_AW'(H_RES) : RAM_AW'(0));
  assign w_rd_addr = RAM_AW'(rd_idx_i) + (rd_bank_i ? RAM_AW'(H_RES) : RAM_AW'(0));

  // Write port: contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[w_wr_addr] <= wr_data_i;
  end

  // Registered read port; blanked reads register 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[w_rd_addr];
    else              rd_data_q <= '0;
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/vid_line_prefetch.sv
`default_nettype none
// ============================================================================
//  Module   : vid_line_prefetch
//  Brief    : Ping-pong line buffer between the frame store and the DVI
//             transmitter. Each preload pulse swaps banks (if the idle bank
//             holds a complete line) and fetches the next line into the idle
//             bank. Pixels are served by hpos with one cycle of latency.
//             Optional macro UNDERRUN_CNT_EN adds a saturating 16-bit count
//             of ignored preloads on port underrun_cnt.
//  Revision : 1.0 - initial release
// ============================================================================
module vid_line_prefetch
  import vid_linebuf_pkg::*;
#(
  parameter int unsigned     H_RES      = c_H_RES_DEFAULT,
  parameter int unsigned     V_RES      = c_V_RES_DEFAULT,
  parameter int unsigned     ADDR_W     = 30,
  parameter longint unsigned FRAME_BASE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vid_preload_line,
  input  logic [10:0]         vid_vpos,
  input  logic [10:0]         vid_hpos,
  input  logic                vid_active_pix,
  output logic [23:0]         vid_data_out,
  vid_line_prefetch_if.master mem,
`ifdef UNDERRUN_CNT_EN
  output logic [15:0]         underrun_cnt,
`endif
  output logic                underrun
);

  localparam int unsigned IDX_W = (H_RES > 1) ? $clog2(H_RES) : 1;

  state_t            state_q, state_d;
  logic              disp_q, disp_d;
  logic              filled_q, filled_d;
  logic [IDX_W-1:0]  wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              underrun_q, underrun_d;

  logic              w_wr_en;
  logic              w_ign_preload;
  logic              w_rd_en;
  logic [10:0]       w_line;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_unused_rd_hi;

  // Next line wraps to 0 from the last active line and throughout vblank.
  assign w_line = (32'(vid_vpos) >= V_RES - 1) ? 11'd0 : vid_vpos + 11'd1;
  assign w_addr = ADDR_W'(64'(FRAME_BASE) + 64'(w_line) * 64'(H_RES));

  assign w_rd_en        = vid_active_pix && (32'(vid_hpos) < H_RES);
  assign w_unused_rd_hi = mem.rd_data[31:24];

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      disp_q     <= 1'b0;
      filled_q   <= 1'b0;
      wcnt_q     <= '0;
      rd_addr_q  <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      disp_q     <= disp_d;
      filled_q   <= filled_d;
      wcnt_q     <= wcnt_d;
      rd_addr_q  <= rd_addr_d;
      underrun_q <= underrun_d;
    end
  end

  // Fetch FSM: preload -> request -> receive burst -> mark bank filled.
  always_comb begin
    state_d       = state_q;
    disp_d        = disp_q;
    filled_d      = filled_q;
    wcnt_d        = wcnt_q;
    rd_addr_d     = rd_addr_q;
    underrun_d    = underrun_q;
    w_wr_en       = 1'b0;
    w_ign_preload = 1'b0;
    case (state_q)
      IDLE: begin
        if (vid_preload_line) begin
          if (filled_q) disp_d = ~disp_q;
          filled_d  = 1'b0;
          wcnt_d    = '0;
          rd_addr_d = w_addr;
          state_d   = REQ;
        end
      end
      REQ: begin
        w_ign_preload = vid_preload_line;
        if (mem.rd_ack) state_d = RECV;
      end
      RECV: begin
        w_ign_preload = vid_preload_line;
        if (mem.rd_data_valid) begin
          w_wr_en = 1'b1;
          if (wcnt_q == IDX_W'(H_RES - 1)) begin
            wcnt_d  = '0;
            state_d = DONE;
          end else begin
            wcnt_d = wcnt_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        filled_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (w_ign_preload) underrun_d = 1'b1;
  end

  assign mem.rd_req  = (state_q == REQ);
  assign mem.rd_addr = rd_addr_q;
  assign underrun    = underrun_q;

`ifdef UNDERRUN_CNT_EN
  logic [15:0] ucnt_q;

  // Saturating count of preloads that arrived while a fetch was in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 ucnt_q <= '0;
    else if (w_ign_preload && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
  end

  assign underrun_cnt = ucnt_q;
`endif

  linebuf_dpram #(
    .H_RES (H_RES),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (w_wr_en),
    .wr_bank_i (~disp_q),
    .wr_idx_i  (wcnt_q),
    .wr_data_i (mem.rd_data[23:0]),
    .rd_en_i   (w_rd_en),
    .rd_bank_i (disp_q),
    .rd_idx_i  (vid_hpos[IDX_W-1:0]),
    .rd_data_o (vid_data_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_vid_line_prefetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vid_line_prefetch
//  Brief    : Self-checking bench for vid_line_prefetch with a bank model and
//             a pixel scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vid_line_prefetch;

  localparam int          H  = 640;
  localparam int          V  = 480;
  localparam logic [29:0] FB = 30'h0010_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pre = 1'b0;
  logic [10:0] vpos = '0;
  logic [10:0] hpos = '0;
  logic        act = 1'b0;
  logic [23:0] dout;
  logic        underrun;
`ifdef UNDERRUN_CNT_EN
  logic [15:0] ucnt;
`endif

  vid_line_prefetch_if #(.ADDR_W(30)) mif ();

  vid_line_prefetch #(
    .H_RES(H), .V_RES(V), .ADDR_W(30), .FRAME_BASE(64'(FB))
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .vid_preload_line (pre),
    .vid_vpos         (vpos),
    .vid_hpos         (hpos),
    .vid_active_pix   (act),
    .vid_data_out     (dout),
    .mem              (mif),
`ifdef UNDERRUN_CNT_EN
    .underrun_cnt     (ucnt),
`endif
    .underrun         (underrun)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [23:0] ref_bank  [2][H];
  bit          ref_known [2][H];
  bit          m_disp, m_filled, m_busy, m_underrun;
  int          m_ucnt;
  logic [29:0] m_addr;
  logic [24:0] sb_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [29:0] exp_addr(input int v);
    int line;
    line = (v >= V - 1) ? 0 : v + 1;
    return FB + 30'(line * H);
  endfunction

  // Push the expected registered pixel for the current hpos/act.
  task automatic push_exp();
    if (act && int'(hpos) < H)
      sb_q.push_back({ref_known[m_disp][hpos], ref_bank[m_disp][hpos]});
    else
      sb_q.push_back({1'b1, 24'h0});
  endtask

  task automatic do_preload(input int v);
    pre  = 1'b1;
    vpos = 11'(v);
    if (m_busy) begin
      m_underrun = 1'b1;
      if (m_ucnt < 65535) m_ucnt++;
    end else begin
      if (m_filled) m_disp = ~m_disp;
      m_filled = 1'b0;
      m_busy   = 1'b1;
      m_addr   = exp_addr(v);
    end
    tick();
    pre = 1'b0;
  endtask

  task automatic ack_now(input int dly);
    repeat (dly) tick();
    mif.rd_ack = 1'b1;
    tick();
    mif.rd_ack = 1'b0;
  endtask

  task automatic send_words(input int from, input int upto, input logic [23:0] base);
    for (int i = from; i < upto; i++) begin
      mif.rd_data_valid = 1'b1;
      mif.rd_data       = {8'h5A, base + 24'(i)};
      ref_bank[~m_disp][i]  = base + 24'(i);
      ref_known[~m_disp][i] = 1'b1;
      if (i == H - 1) begin
        m_filled = 1'b1;
        m_busy   = 1'b0;
      end
      tick();
    end
    mif.rd_data_valid = 1'b0;
    mif.rd_data       = 32'hFFFF_FFFF;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (dout !== 24'h0) begin n_fail++; $display("FAIL reset_dout actual=%h required=0", dout); end
    n_checks++; if (mif.rd_req !== 1'b0) begin n_fail++; $display("FAIL reset_rd_req actual=%b required=0", mif.rd_req); end
    n_checks++; if (mif.rd_addr !== 30'h0) begin n_fail++; $display("FAIL reset_rd_addr actual=%h required=0", mif.rd_addr); end
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun actual=%b required=0", underrun); end
`ifdef UNDERRUN_CNT_EN
    n_checks++; if (ucnt !== 16'h0) begin n_fail++; $display("FAIL reset_ucnt actual=%0d required=0", ucnt); end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_display();
    int          hl [4] = '{5, 0, 639, 321};
    logic [24:0] e;
    do_preload(0);
    n_checks++; if (mif.rd_req !== 1'b1) begin n_fail++; $display("FAIL fill_req actual=%b required=1", mif.rd_req); end
    n_checks++; if (mif.rd_addr !== m_addr) begin n_fail++; $display("FAIL fill_addr actual=%h required=%h", mif.rd_addr, m_addr); end
    ack_now(2);
    send_words(0, H, 24'hAA0000);
    do_preload(1);
    n_checks++; if (mif.rd_addr !== FB + 30'd1280) begin n_fail++; $display("FAIL fill_addr2 actual=%h required=%h", mif.rd_addr, FB + 30'd1280); end
    act = 1'b1;
    foreach (hl[k]) begin
      hpos = 11'(hl[k]);
      push_exp();
      tick();
      e = sb_q.pop_front();
      n_checks++; if (dout !== e[23:0]) begin n_fail++; $display("FAIL fill_pix hpos=%0d actual=%h required=%h", hl[k], dout, e[23:0]); end
    end
    hpos = 11'd5; tick(); tick();
    n_checks++; if (dout !== 24'hAA0005) begin n_fail++; $display("FAIL fill_pix5 actual=%h required=aa0005", dout); end
    act = 1'b0;
    ack_now(0);
    send_words(0, H, 24'hBB0000);
  endtask

  task automatic test_addr_swap();
    int          vl [3] = '{9, 479, 490};
    logic [24:0] e;
    foreach (vl[k]) begin
      act  = 1'b1;
      hpos = 11'(7 + k);
      push_exp();
      do_preload(vl[k]);
      e = sb_q.pop_front();
      n_checks++; if (dout !== e[23:0]) begin n_fail++; $display("FAIL swap_old v=%0d actual=%h required=%h", vl[k], dout, e[23:0]); end
      push_exp();
      tick();
      e = sb_q.pop_front();
      n_checks++; if (dout !== e[23:0]) begin n_fail++; $display("FAIL swap_new v=%0d actual=%h required=%h", vl[k], dout, e[23:0]); end
      n_checks++; if (mif.rd_addr !== m_addr) begin n_fail++; $display("FAIL addr v=%0d actual=%h required=%h", vl[k], mif.rd_addr, m_addr); end
      act = 1'b0;
      ack_now(0);
      send_words(0, H, 24'hC00000 + (24'(k) << 16));
    end
    n_checks++; if (m_addr !== FB) begin n_fail++; $display("FAIL addr_wrap actual=%h required=%h", m_addr, FB); end
  endtask

  task automatic test_handshake();
    do_preload(20);
    for (int c = 0; c < 20; c++) begin
      mif.rd_data_valid = (c == 3 || c == 4);
      mif.rd_data       = 32'h00DEAD00;
      n_checks++; if (mif.rd_req !== 1'b1 || mif.rd_addr !== m_addr) begin
        n_fail++; $display("FAIL hs_hold cyc=%0d actual=%b/%h required=1/%h", c, mif.rd_req, mif.rd_addr, m_addr);
      end
      tick();
    end
    mif.rd_data_valid = 1'b0;
    mif.rd_ack = 1'b1;
    n_checks++; if (mif.rd_req !== 1'b1) begin n_fail++; $display("FAIL hs_req_at_ack actual=%b required=1", mif.rd_req); end
    tick();
    mif.rd_ack = 1'b0;
    n_checks++; if (mif.rd_req !== 1'b0) begin n_fail++; $display("FAIL hs_drop actual=%b required=0", mif.rd_req); end
    send_words(0, H, 24'h110000);
  endtask

  task automatic test_underrun();
    logic [24:0] e;
    int          hl [3] = '{0, 4, 639};
    do_preload(30);
    act = 1'b1;
    foreach (hl[k]) begin
      hpos = 11'(hl[k]);
      push_exp();
      tick();
      e = sb_q.pop_front();
      n_checks++; if (dout !== e[23:0]) begin n_fail++; $display("FAIL ur_pre hpos=%0d actual=%h required=%h", hl[k], dout, e[23:0]); end
    end
    ack_now(1);
    send_words(0, 300, 24'hDD0000);
    hpos = 11'd2;
    push_exp();
    do_preload(31);
    e = sb_q.pop_front();
    n_checks++; if (dout !== e[23:0]) begin n_fail++; $display("FAIL ur_noswap actual=%h required=%h", dout, e[23:0]); end
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_flag actual=%b required=1", underrun); end
    hpos = 11'd639;
    push_exp();
    tick();
    e = sb_q.pop_front();
    n_checks++; if (dout !== e[23:0]) begin n_fail++; $display("FAIL ur_bank actual=%h required=%h", dout, e[23:0]); end
    n_checks++; if (mif.rd_req !== 1'b0) begin n_fail++; $display("FAIL ur_noreq actual=%b required=0", mif.rd_req); end
    send_words(300, H, 24'hDD0000);
`ifdef UNDERRUN_CNT_EN
    n_checks++; if (ucnt !== 16'(m_ucnt)) begin n_fail++; $display("FAIL ur_cnt actual=%0d required=%0d", ucnt, m_ucnt); end
`endif
    do_preload(32);
    hpos = 11'd299;
    push_exp();
    tick();
    e = sb_q.pop_front();
    n_checks++; if (dout !== e[23:0]) begin n_fail++; $display("FAIL ur_after actual=%h required=%h", dout, e[23:0]); end
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_sticky actual=%b required=1", underrun); end
    act = 1'b0;
    ack_now(0);
    send_words(0, H, 24'h220000);
  endtask

  task automatic test_blank_range();
    logic [24:0] e;
    bit          al [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    int          hl [4] = '{5, 700, 640, 639};
    foreach (al[k]) begin
      act  = al[k];
      hpos = 11'(hl[k]);
      push_exp();
      tick();
      e = sb_q.pop_front();
      n_checks++; if (dout !== e[23:0]) begin n_fail++; $display("FAIL blank act=%0d hpos=%0d actual=%h required=%h", al[k], hl[k], dout, e[23:0]); end
    end
    act = 1'b0;
  endtask

  task automatic test_reset_mid_recv();
    logic [24:0] e;
    int          hl [3] = '{0, 100, 639};
    do_preload(40);
    ack_now(0);
    send_words(0, 100, 24'hEE0000);
    act  = 1'b1;
    hpos = 11'd3;
    tick();
    rst_n = 1'b0;
    #2;
    m_disp = 1'b0; m_filled = 1'b0; m_busy = 1'b0; m_underrun = 1'b0; m_ucnt = 0;
    n_checks++; if (dout !== 24'h0) begin n_fail++; $display("FAIL rst_dout actual=%h required=0", dout); end
    n_checks++; if (mif.rd_req !== 1'b0 || mif.rd_addr !== 30'h0) begin n_fail++; $display("FAIL rst_rd actual=%b/%h required=0/0", mif.rd_req, mif.rd_addr); end
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL rst_underrun actual=%b required=0", underrun); end
`ifdef UNDERRUN_CNT_EN
    n_checks++; if (ucnt !== 16'h0) begin n_fail++; $display("FAIL rst_ucnt actual=%0d required=0", ucnt); end
`endif
    act = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    do_preload(50);
    n_checks++; if (mif.rd_req !== 1'b1 || mif.rd_addr !== m_addr) begin n_fail++; $display("FAIL rst_refetch actual=%b/%h required=1/%h", mif.rd_req, mif.rd_addr, m_addr); end
    ack_now(0);
    send_words(0, H, 24'h330000);
    do_preload(51);
    act = 1'b1;
    foreach (hl[k]) begin
      hpos = 11'(hl[k]);
      push_exp();
      tick();
      e = sb_q.pop_front();
      n_checks++; if (dout !== e[23:0]) begin n_fail++; $display("FAIL rst_fill hpos=%0d actual=%h required=%h", hl[k], dout, e[23:0]); end
    end
    act = 1'b0;
    ack_now(0);
    send_words(0, H, 24'h440000);
  endtask

  initial begin
    mif.rd_ack        = 1'b0;
    mif.rd_data_valid = 1'b0;
    mif.rd_data       = '0;
    m_disp = 1'b0; m_filled = 1'b0; m_busy = 1'b0; m_underrun = 1'b0; m_ucnt = 0; m_addr = '0;
    foreach (ref_known[b, i]) ref_known[b][i] = 1'b0;
    test_reset();
    test_fill_display();
    test_addr_swap();
    test_handshake();
    test_underrun();
    test_blank_range();
    test_reset_mid_recv();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
